spi_tx_engine: RTL and testbench
================================

SPI_TX_ENGINE -- requirements
Module: spi_tx_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 41: FIFO word width; the frame layout is bit 40 = wr (1 write, 0 read), bits 39:32 = addr, bits 31:0 = data.
REQ-002 SHALL have parameter CLK_DIV, default 2: SCLK half-period in rd_clk cycles; legal range is 1..255.
REQ-003 SHALL have port rd_clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rd_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port rd_en, output, 1 bit: FIFO pop request.
REQ-006 SHALL have port rd_data, input, DATA_WIDTH bits: FIFO read word, valid in the cycle after rd_en.
REQ-007 SHALL have port empty, input, 1 bit: FIFO empty flag.
REQ-008 SHALL have port sclk, output, 1 bit: SPI clock in mode 0 (idle low).
REQ-009 SHALL have port cs_n, output, 1 bit: SPI chip select, active low.
REQ-010 SHALL have port mosi, output, 1 bit: serial data out, MSB first.
REQ-011 SHALL have port miso, input, 1 bit: serial data in.
REQ-012 SHALL have port rx_data, output, 32 bits: read-return data.
REQ-013 SHALL have port rx_valid, output, 1 bit: one-cycle pulse marking rx_data valid.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, POP, LOAD, SETUP, SHIFT, HOLD, GAP.
REQ-016 IDLE: if empty=0, SHALL go to POP; otherwise SHALL stay in IDLE.
REQ-017 POP: SHALL assert rd_en for exactly one cycle, then go to LOAD; rd_en SHALL never be asserted while empty=1 was sampled in IDLE.
REQ-018 LOAD: SHALL register rd_data into the shift register, drive cs_n low, present bit 40 on mosi, then go to SETUP.
REQ-019 SETUP: SHALL hold sclk low for CLK_DIV cycles, then go to SHIFT.
REQ-020 SHIFT: SHALL toggle sclk every CLK_DIV cycles.
REQ-021 SHIFT: SHALL sample miso on each rising edge.
REQ-022 SHIFT: SHALL update mosi to the next bit on each falling edge.
REQ-023 SHIFT: after the 41st falling edge, SHALL go to HOLD with sclk low.
REQ-024 HOLD: SHALL keep cs_n low for CLK_DIV cycles, then raise cs_n and go to GAP.
REQ-025 HOLD exit: if the frame is a read (wr=0), SHALL load the last 32 sampled miso bits into rx_data (first sampled bit lands in bit 31) and pulse rx_valid for 1 cycle.
REQ-026 HOLD exit: if the frame is a write, rx_valid SHALL stay 0 and rx_data SHALL be unchanged.
REQ-027 GAP: SHALL keep cs_n high for CLK_DIV cycles, then go to IDLE.
REQ-028 Frame latency from IDLE-with-!empty to return to IDLE SHALL be 2 + CLK_DIV*(2*DATA_WIDTH + 3) cycles (172 cycles for CLK_DIV=2).
REQ-029 Changes of empty after POP SHALL NOT affect the frame in flight.
REQ-030 Back-to-back frames SHALL be separated by at least CLK_DIV+1 cycles of cs_n high.
REQ-031 The half-period counter SHALL wrap at CLK_DIV-1 with no off-by-one; the bit counter SHALL count 0..40.

Reset
REQ-032 On rd_rst_n=0, outputs SHALL immediately become: rd_en=0, sclk=0, cs_n=1, mosi=0, rx_data=0, rx_valid=0, busy=0; the FSM SHALL be IDLE.
REQ-033 A reset asserted mid-frame SHALL abort the frame; the popped word is discarded and no rx_valid is produced.
REQ-034 After reset release, the first pop SHALL occur no earlier than the second rd_clk edge.

Structure
REQ-035 Shared package spi_bridge_pkg SHALL hold the state enum, DATA_WIDTH, and the field position constants (WR_BIT=40, ADDR_MSB=39, ADDR_LSB=32, DATA_MSB=31).
REQ-036 Sub-module spi_sclk_gen SHALL hold the half-period counter and produce rise/fall strobes plus sclk.

Verification
REQ-037 Scenario: empty=1 held for 100 cycles -> rd_en=0, cs_n=1, busy=0 throughout.
REQ-038 Scenario: one word 0x1_A5_DEADBEEF, CLK_DIV=2 -> rd_en pulses 1 cycle; mosi carries the 41 bits MSB-first across 41 rising edges; cs_n low to high spans 168 cycles; rx_valid=0.
REQ-039 Scenario: read word 0x0_3C_00000000 with the slave driving 0x12345678 on the last 32 bits -> rx_data=0x12345678 and rx_valid=1 for 1 cycle as cs_n rises.
REQ-040 Scenario: three words pre-loaded -> three frames, each with cs_n high for at least 3 cycles between frames, and exactly 3 rd_en pulses.
REQ-041 Scenario: rd_rst_n dropped at rising edge 20 of a frame -> cs_n=1 and sclk=0 immediately; after release, the next word is sent cleanly and the aborted word is never transmitted.
REQ-042 Scenario: CLK_DIV=1 and CLK_DIV=255 -> sclk period is 2 and 510 cycles respectively; the frame latency formula holds.

Source files
------------

// File: rtl/spi_bridge_pkg.sv
// Shared types and frame layout for the SPI bridge.
// Frame: {wr, addr[7:0], data[31:0]}, shifted MSB first.
package spi_bridge_pkg;

  localparam int DATA_WIDTH = 41;
  localparam int WR_BIT     = 40;
  localparam int ADDR_MSB   = 39;
  localparam int ADDR_LSB   = 32;
  localparam int DATA_MSB   = 31;
  localparam int RX_W       = DATA_MSB + 1;
  localparam int DIV_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  function automatic logic [7:0] frame_addr(
    input logic [DATA_WIDTH-1:0] w
  );
    return w[ADDR_MSB:ADDR_LSB];
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer for the SPI engine: one tick every CLK_DIV cycles,
// toggling a mode-0 SCLK and flagging rise/fall ahead of each edge.
module spi_sclk_gen
  import spi_bridge_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic toggle_i,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o,
  output logic sclk_o
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;

  always_comb begin
    tick_o = en_i && (cnt_q == LAST);
    rise_o = tick_o && toggle_i && !sclk_q;
    fall_o = tick_o && toggle_i && sclk_q;
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Outside SHIFT the clock is parked low.
    if (rise_o) begin
      sclk_d = 1'b1;
    end else if (fall_o || !toggle_i) begin
      sclk_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_tx_engine.sv
// Pops frames from a FIFO and shifts them out over SPI mode 0,
// returning the last 32 MISO bits of read frames on rx_data.
module spi_tx_engine
  import spi_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = spi_bridge_pkg::DATA_WIDTH,
  parameter int CLK_DIV    = 2
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  empty,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso,
  output logic [31:0]           rx_data,
  output logic                  rx_valid,
  output logic                  busy
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [RX_W-1:0]       rxsh_q, rxsh_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  wr_q, wr_d;
  logic                  cs_n_q, cs_n_d;
  logic [RX_W-1:0]       rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;

  logic gen_en, gen_tog;
  logic tick, rise, fall;

  assign gen_en  = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                   (state_q == ST_HOLD)  || (state_q == ST_GAP);
  assign gen_tog = (state_q == ST_SHIFT);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .clk_i    (rd_clk),
    .rst_ni   (rd_rst_n),
    .en_i     (gen_en),
    .toggle_i (gen_tog),
    .tick_o   (tick),
    .rise_o   (rise),
    .fall_o   (fall),
    .sclk_o   (sclk)
  );

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    rxsh_d     = rxsh_q;
    bit_d      = bit_q;
    wr_d       = wr_q;
    cs_n_d     = cs_n_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) state_d = ST_POP;
      end
      ST_POP: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sh_d    = rd_data;
        wr_d    = rd_data[WR_BIT];
        bit_d   = '0;
        cs_n_d  = 1'b0;
        state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (rise) rxsh_d = {rxsh_q[RX_W-2:0], miso};
        if (fall) begin
          sh_d = sh_q << 1;
          if (bit_q == LAST_BIT) begin
            state_d = ST_HOLD;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          cs_n_d  = 1'b1;
          state_d = ST_GAP;
          if (!wr_q) begin
            rx_data_d  = rxsh_q;
            rx_valid_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      rxsh_q     <= '0;
      bit_q      <= '0;
      wr_q       <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      rxsh_q     <= rxsh_d;
      bit_q      <= bit_d;
      wr_q       <= wr_d;
      cs_n_q     <= cs_n_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // MOSI is the shifter MSB; the shifter drains to zero after the frame.
  assign mosi     = sh_q[DATA_WIDTH-1];
  assign rd_en    = (state_q == ST_POP);
  assign busy     = (state_q != ST_IDLE);
  assign cs_n     = cs_n_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_tx_engine.sv
// Bench for spi_tx_engine: FIFO + SPI slave models, frame-level
// scoreboard, vector table, reset abort and CLK_DIV extremes.
module tb_spi_tx_engine;

  typedef struct {
    logic [40:0] word;
    logic [40:0] slv;
    logic        exp_valid;
    logic [31:0] exp_rx;
  } vec_t;

  localparam logic [40:0] AW0 = 41'h0_55_0F0F0F0F;
  localparam logic [40:0] AW1 = 41'h1_AA_12345678;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rd_en, empty, sclk, cs_n, mosi, miso, rx_valid, busy;
  logic [40:0] rd_data = '0;
  logic [31:0] rx_data;
  logic [40:0] slv = '0;

  logic [40:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;

  logic        a_empty [2];
  logic        a_rden [2], a_sclk [2], a_cs [2], a_mosi [2];
  logic        a_rxv [2], a_busy [2];
  logic [31:0] a_rx [2];

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int n_rden = 0, n_badpop = 0, n_rise = 0, n_sclk_bad = 0;
  int n_rxv = 0, n_rxp = 0, n_rxa = 0;
  int bz_run = 0, hi_run = 0, cs_lo = 0, fr_rise = 0;
  bit seen = 0;
  logic cs_prev = 1'b1, sclk_prev = 1'b0, rx_prev = 1'b0;
  logic [40:0] cap = '0;
  int bz_runs[$], gaps[$], fr_rises[$], fr_lo[$];
  logic [40:0] fr_cap[$];

  int a_brun [2] = '{0, 0};
  int a_lat  [2] = '{0, 0};
  int a_runs [2] = '{0, 0};
  int a_rise [2] = '{0, 0};
  int a_bad  [2] = '{0, 0};
  int a_per  [2] = '{0, 0};
  int a_last [2] = '{-1, -1};
  int a_exp  [2] = '{2, 510};
  logic a_sprev [2] = '{1'b0, 1'b0};

  assign empty = (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  always_comb miso = (!cs_n && fr_rise < 41) ? slv[40 - fr_rise] : 1'b0;

  spi_tx_engine #(.DATA_WIDTH(41), .CLK_DIV(2)) dut (
    .rd_clk(clk), .rd_rst_n(rst_n), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy));

  spi_tx_engine #(.DATA_WIDTH(41), .CLK_DIV(1)) dut_d1 (
    .rd_clk(clk), .rd_rst_n(rst_n), .rd_en(a_rden[0]), .rd_data(AW0),
    .empty(a_empty[0]), .sclk(a_sclk[0]), .cs_n(a_cs[0]),
    .mosi(a_mosi[0]), .miso(1'b0), .rx_data(a_rx[0]),
    .rx_valid(a_rxv[0]), .busy(a_busy[0]));

  spi_tx_engine #(.DATA_WIDTH(41), .CLK_DIV(255)) dut_d255 (
    .rd_clk(clk), .rd_rst_n(rst_n), .rd_en(a_rden[1]), .rd_data(AW1),
    .empty(a_empty[1]), .sclk(a_sclk[1]), .cs_n(a_cs[1]),
    .mosi(a_mosi[1]), .miso(1'b0), .rx_data(a_rx[1]),
    .rx_valid(a_rxv[1]), .busy(a_busy[1]));

  // Monitor: FIFO pop side, frame capture, alt-instance timing.
  always @(negedge clk) begin
    cyc++;
    if (rd_en) begin
      n_rden++;
      if (wr_ptr == rd_ptr) n_badpop++;
      else begin
        rd_data = mem[rd_ptr];
        rd_ptr++;
      end
    end
    if (busy) bz_run++;
    else if (bz_run != 0) begin
      bz_runs.push_back(bz_run);
      bz_run = 0;
    end
    if (!cs_n && cs_prev) begin
      if (seen) gaps.push_back(hi_run);
      seen = 1;
      cap = '0;
      fr_rise = 0;
      cs_lo = 0;
    end
    if (cs_n) hi_run++;
    else begin
      hi_run = 0;
      cs_lo++;
    end
    if (sclk && !sclk_prev) begin
      n_rise++;
      fr_rise++;
      cap = {cap[39:0], mosi};
    end
    if (sclk && cs_n) n_sclk_bad++;
    if (cs_n && !cs_prev) begin
      fr_cap.push_back(cap);
      fr_rises.push_back(fr_rise);
      fr_lo.push_back(cs_lo);
    end
    if (rx_valid) begin
      n_rxv++;
      if (!rx_prev) n_rxp++;
      if (cs_n && !cs_prev) n_rxa++;
    end
    cs_prev = cs_n;
    sclk_prev = sclk;
    rx_prev = rx_valid;
    for (int k = 0; k < 2; k++) begin
      if (a_busy[k]) a_brun[k]++;
      else if (a_brun[k] != 0) begin
        a_lat[k] = a_brun[k];
        a_runs[k]++;
        a_brun[k] = 0;
      end
      if (a_sclk[k] && !a_sprev[k]) begin
        a_rise[k]++;
        if (a_last[k] >= 0) begin
          a_per[k] = cyc - a_last[k];
          if (a_per[k] != a_exp[k]) a_bad[k]++;
        end
        a_last[k] = cyc;
      end
      if (a_cs[k]) a_last[k] = -1;
      a_sprev[k] = a_sclk[k];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic push(input logic [40:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic wait_runs(input int target, input int limit,
                           output bit ok);
    ok = 0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      #1;
      if (bz_runs.size() >= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: busy runs %0d, expected %0d",
               bz_runs.size(), target);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int f0, b0, rd0, rxp0, rxv0, rxa0;
    bit ok;
    f0 = fr_cap.size();
    b0 = bz_runs.size();
    rd0 = n_rden;
    rxp0 = n_rxp;
    rxv0 = n_rxv;
    rxa0 = n_rxa;
    @(negedge clk);
    #1;
    slv = v.slv;
    push(v.word);
    wait_runs(b0 + 1, 400, ok);
    if (!ok) return;
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_frames", idx), fr_cap.size() - f0, 1);
    if (fr_cap.size() > f0) begin
      chk($sformatf("v%0d_mosi", idx), fr_cap[f0], v.word);
      chk($sformatf("v%0d_rises", idx), fr_rises[f0], 41);
      chk($sformatf("v%0d_cs_low", idx), fr_lo[f0], 168);
    end
    chk($sformatf("v%0d_latency", idx), bz_runs[b0], 2 + 2 * 85);
    chk($sformatf("v%0d_rd_en", idx), n_rden - rd0, 1);
    chk($sformatf("v%0d_rxv_pulses", idx), n_rxp - rxp0, v.exp_valid);
    chk($sformatf("v%0d_rxv_cycles", idx), n_rxv - rxv0, v.exp_valid);
    chk($sformatf("v%0d_rxv_at_cs", idx), n_rxa - rxa0, v.exp_valid);
    chk($sformatf("v%0d_rx_data", idx), rx_data, v.exp_rx);
  endtask

  task automatic run_alt(input int k, input int d);
    int r0, n0, p0;
    bit got;
    r0 = a_rise[k];
    n0 = a_runs[k];
    p0 = a_bad[k];
    got = 0;
    @(negedge clk);
    #1;
    a_empty[k] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (a_rden[k]) begin
        got = 1;
        break;
      end
    end
    a_empty[k] = 1'b1;
    chk($sformatf("div%0d_pop", d), got, 1);
    got = 0;
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      #1;
      if (a_runs[k] > n0) begin
        got = 1;
        break;
      end
    end
    chk($sformatf("div%0d_done", d), got, 1);
    chk($sformatf("div%0d_latency", d), a_lat[k], 2 + d * 85);
    chk($sformatf("div%0d_rises", d), a_rise[k] - r0, 41);
    chk($sformatf("div%0d_period", d), a_per[k], 2 * d);
    chk($sformatf("div%0d_period_bad", d), a_bad[k] - p0, 0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    logic [31:0] rx_ref;
    logic [40:0] w3 [3];
    logic [40:0] wa, wb;
    int bad, f0, b0, rd0, rxp0, g0, r0, rel, first, nr;
    bit ok;

    a_empty[0] = 1'b1;
    a_empty[1] = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (rd_en || !cs_n || busy) bad++;
    end
    chk("idle_empty", bad, 0);

    vecs[0] = '{41'h1_A5_DEADBEEF, 41'h1FF_FFFFFFFF, 1'b0, 32'h0};
    vecs[1] = '{41'h0_3C_00000000, {9'h0, 32'h12345678},
                1'b1, 32'h12345678};
    rx_ref = 32'h12345678;
    for (int i = 2; i < 8; i++) begin
      logic [40:0] w, s;
      w = {(i % 3 == 0), 8'($urandom), 32'($urandom)};
      s = {9'($urandom), 32'($urandom)};
      if (!w[40]) rx_ref = s[31:0];
      vecs[i] = '{w, s, !w[40], rx_ref};
    end
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    f0 = fr_cap.size();
    b0 = bz_runs.size();
    rd0 = n_rden;
    rxp0 = n_rxp;
    g0 = gaps.size();
    @(negedge clk);
    #1;
    slv = {9'($urandom), 32'($urandom)};
    w3[0] = {1'b0, 8'($urandom), 32'($urandom)};
    w3[1] = {1'b1, 8'($urandom), 32'($urandom)};
    w3[2] = {1'b0, 8'($urandom), 32'($urandom)};
    nr = 2;
    rx_ref = slv[31:0];
    for (int j = 0; j < 3; j++) push(w3[j]);
    wait_runs(b0 + 3, 1000, ok);
    @(negedge clk);
    #1;
    chk("b2b_rd_en", n_rden - rd0, 3);
    chk("b2b_frames", fr_cap.size() - f0, 3);
    if (fr_cap.size() >= f0 + 3 && gaps.size() >= g0 + 3) begin
      for (int j = 0; j < 3; j++)
        chk($sformatf("b2b_mosi%0d", j), fr_cap[f0 + j], w3[j]);
      for (int j = 1; j < 3; j++)
        chk_rng($sformatf("b2b_gap%0d", j), gaps[g0 + j], 3, 1000);
    end
    chk("b2b_rxv", n_rxp - rxp0, nr);
    chk("b2b_rx_data", rx_data, rx_ref);

    f0 = fr_cap.size();
    rd0 = n_rden;
    rxp0 = n_rxp;
    r0 = n_rise;
    @(negedge clk);
    #1;
    slv = {9'($urandom), 32'($urandom)};
    wa = {1'b0, 8'h5A, 32'($urandom)};
    push(wa);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      #1;
      if (n_rise - r0 >= 20) break;
    end
    chk("abort_reached", n_rise - r0, 20);
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rx_valid", rx_valid, 0);
    chk("abort_mosi", mosi, 0);
    chk("abort_rx_data", rx_data, 0);
    repeat (2) @(negedge clk);
    #1;
    wb = {1'b1, 8'hC3, 32'($urandom)};
    push(wb);
    @(negedge clk);
    #1;
    b0 = bz_runs.size();
    rst_n = 1'b1;
    rel = cyc;
    first = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (n_rden - rd0 >= 2) begin
        first = cyc - rel;
        break;
      end
    end
    chk_rng("rst_first_pop", first, 1, 3);
    wait_runs(b0 + 1, 400, ok);
    repeat (50) @(negedge clk);
    #1;
    chk("abort_frames", fr_cap.size() - f0, 2);
    if (fr_cap.size() >= f0 + 2) begin
      chk("abort_partial", fr_rises[f0], 20);
      chk("abort_next_mosi", fr_cap[f0 + 1], wb);
      chk("abort_next_rises", fr_rises[f0 + 1], 41);
    end
    chk("abort_rd_en", n_rden - rd0, 2);
    chk("abort_no_rxv", n_rxp - rxp0, 0);
    chk("abort_rx_kept", rx_data, 0);
    chk("abort_idle", busy, 0);

    run_alt(0, 1);
    run_alt(1, 255);

    chk("pop_when_empty", n_badpop, 0);
    chk("sclk_idle_low", n_sclk_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
